// File: rtl/mont_pkg.sv
`default_nettype none
// ============================================================================
// mont_pkg
// Shared types and constants for the bit-serial Montgomery multiplier.
// Revision: 1.0
// ============================================================================
package mont_pkg;

  localparam int MONT_W = 381;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRECOMP = 3'd1,
    LOOP    = 3'd2,
    REDUCE  = 3'd3,
    DONE    = 3'd4
  } mont_state_t;

  // Operand mux select, encoded as {a_sh[0], quotient bit}
  localparam logic [1:0] c_sel_zero = 2'b00;
  localparam logic [1:0] c_sel_b    = 2'b10;
  localparam logic [1:0] c_sel_m    = 2'b01;
  localparam logic [1:0] c_sel_bm   = 2'b11;

  function automatic logic [1:0] mont_sel(input logic a0, input logic c0, input logic b0);
    return {a0, c0 ^ (a0 & b0)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mont_addsub.sv
`default_nettype none
// ============================================================================
// mont_addsub
// Single shared W-bit adder/subtractor (o_sum = i_a +/- i_b).
// Revision: 1.0
// ============================================================================
module mont_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum
);

  // Two's-complement subtract: invert the addend and inject the carry-in
  assign o_sum = i_a + (i_b ^ {W{i_sub}}) + W'(i_sub);

endmodule
`default_nettype wire

// File: rtl/montgomery_mult_hs.sv
`default_nettype none
// ============================================================================
// montgomery_mult_hs
// Radix-2 bit-serial Montgomery multiplier (a*b*2^-WIDTH mod m), valid/ready I/O.
// Revision: 1.0
// ============================================================================
module montgomery_mult_hs
  import mont_pkg::*;
#(
  parameter int WIDTH = MONT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_err
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = WIDTH + 2;

  mont_state_t      r_state;
  mont_state_t      w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH:0]   r_bm;
  logic [AW-1:0]    r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic             w_in_fire;
  logic             w_last;
  logic [1:0]       w_sel;
  logic [AW-1:0]    w_operand;
  logic [AW-1:0]    w_add_a;
  logic [AW-1:0]    w_add_b;
  logic             w_sub;
  logic [AW-1:0]    w_sum;

  assign w_in_fire = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_sel     = mont_sel(r_a_sh[0], r_c[0], r_b[0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = in_m[0] ? PRECOMP : DONE;
        end
      end
      PRECOMP: w_next = LOOP;
      LOOP: begin
        if (w_last) begin
          w_next = REDUCE;
        end
      end
      REDUCE: w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_operand = '0;
    case (w_sel)
      c_sel_b:    w_operand = {2'b00, r_b};
      c_sel_m:    w_operand = {2'b00, r_m};
      c_sel_bm:   w_operand = {1'b0, r_bm};
      c_sel_zero: w_operand = '0;
      default:    w_operand = '0;
    endcase
  end

  // One carry chain serves b+m, C+operand and C-m depending on the phase
  always_comb begin
    w_add_a = r_c;
    w_add_b = {2'b00, r_m};
    w_sub   = 1'b0;
    case (r_state)
      PRECOMP: w_add_a = {2'b00, r_b};
      LOOP:    w_add_b = w_operand;
      REDUCE:  w_sub   = 1'b1;
      default: ;
    endcase
  end

  mont_addsub #(
    .W(AW)
  ) u_addsub (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_sub (w_sub),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a_sh <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_bm   <= '0;
      r_c    <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_a_sh <= in_a;
            r_b    <= in_b;
            r_m    <= in_m;
            r_c    <= '0;
            r_err  <= ~in_m[0];
          end
        end
        PRECOMP: begin
          r_bm  <= w_sum[WIDTH:0];
          r_c   <= '0;
          r_cnt <= '0;
        end
        LOOP: begin
          r_c    <= {1'b0, w_sum[AW-1:1]};
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_cnt  <= r_cnt + CW'(1);
        end
        REDUCE: begin
          // C < 2m on entry, so a single non-negative C-m finishes the reduction
          if (!w_sum[AW-1]) begin
            r_c <= w_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign result  = r_c[WIDTH-1:0];
  assign out_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_montgomery_mult_hs.sv
`default_nettype none
// Self-checking bench: an 8-bit and a 381-bit instance against an arithmetic reference.
module tb_montgomery_mult_hs;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, out_err8;
  logic [7:0]   in_a8, in_b8, in_m8, result8;
  logic         in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_err_w;
  logic [380:0] in_a_w, in_b_w, in_m_w, result_w;

  int n_checks = 0;
  int n_pass   = 0;
  logic [767:0] mm;

  montgomery_mult_hs #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_m(in_m8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .out_err(out_err8)
  );

  montgomery_mult_hs #(.WIDTH(381)) dut381 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_a(in_a_w), .in_b(in_b_w), .in_m(in_m_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .result(result_w), .out_err(out_err_w)
  );

  function automatic void check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endfunction

  // r is the unique value in [0,m) with r*2^8 == a*b (mod m)
  function automatic int mont8(input int a, input int b, input int m);
    for (int r = 0; r < m; r++) begin
      if (((r * 256) % m) == ((a * b) % m)) return r;
    end
    return -1;
  endfunction

  function automatic logic [767:0] rand_below_m();
    logic [767:0] t;
    t = '0;
    for (int i = 0; i < 12; i++) t = (t << 32) | 768'($urandom);
    return t % mm;
  endfunction

  task automatic send8(input int a, input int b, input int m);
    @(negedge clk);
    in_a8 = 8'(a); in_b8 = 8'(b); in_m8 = 8'(m); in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic accept8();
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
  endtask

  task automatic run8(input string tag, input int a, input int b, input int m);
    int lat;
    send8(a, b, m);
    wait8(lat);
    check({tag, " latency"}, 384'(lat), 384'd10);
    check({tag, " result"}, 384'(result8), 384'(mont8(a, b, m)));
    check({tag, " err"}, 384'(out_err8), 384'd0);
    accept8();
  endtask

  task automatic run_w(input logic [380:0] a, input logic [380:0] b, output logic [380:0] r, output int lat);
    @(negedge clk);
    in_a_w = a; in_b_w = b; in_m_w = mm[380:0]; in_valid_w = 1'b1;
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    lat = 0;
    while (out_valid_w !== 1'b1 && lat < 500) begin
      @(posedge clk); #1; lat++;
    end
    r = result_w;
    @(negedge clk); out_ready_w = 1'b1;
    @(posedge clk); #1; out_ready_w = 1'b0;
  endtask

  initial begin
    int lat;
    int a, b, m;
    bit seen;
    logic [380:0] ra, rb, rr;
    logic [767:0] t1, t2;

    mm = (768'd1 << 381) - (768'd1 << 128) - (768'd1 << 96) + (768'd1 << 32) - 768'd1;
    resetn = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; in_a8 = '0; in_b8 = '0; in_m8 = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0; in_a_w = '0; in_b_w = '0; in_m_w = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 384'(in_ready8), 384'd1);
    check("reset out_valid", 384'(out_valid8), 384'd0);
    check("reset out_err", 384'(out_err8), 384'd0);
    check("reset result", 384'(result8), 384'd0);
    check("reset w in_ready", 384'(in_ready_w), 384'd1);
    check("reset w result", 384'(result_w), 384'd0);
    @(negedge clk); resetn = 1'b1;

    run8("5x7 m13", 5, 7, 13);

    // Back-pressure: output held while out_ready stays low
    send8(12, 12, 13);
    wait8(lat);
    check("12x12 latency", 384'(lat), 384'd10);
    for (int i = 0; i < 5; i++) begin
      check("hold result", 384'(result8), 384'd3);
      check("hold out_valid", 384'(out_valid8), 384'd1);
      check("hold in_ready", 384'(in_ready8), 384'd0);
      @(posedge clk); #1;
    end
    accept8();
    check("after accept in_ready", 384'(in_ready8), 384'd1);
    check("after accept out_valid", 384'(out_valid8), 384'd0);

    // Even modulus bypasses the datapath; result is up right after the transfer edge
    send8(3, 4, 12);
    check("even out_valid", 384'(out_valid8), 384'd1);
    check("even out_err", 384'(out_err8), 384'd1);
    check("even result", 384'(result8), 384'd0);
    accept8();

    // Back-to-back with in_valid held high
    @(negedge clk);
    in_a8 = 8'd0; in_b8 = 8'd9; in_m8 = 8'd13; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_a8 = 8'd9; in_b8 = 8'd11;
    wait8(lat);
    check("b2b first latency", 384'(lat), 384'd10);
    check("b2b first result", 384'(result8), 384'd0);
    check("b2b busy in_ready", 384'(in_ready8), 384'd0);
    @(negedge clk); out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready8 = 1'b0;
    check("b2b idle in_ready", 384'(in_ready8), 384'd1);
    check("b2b idle out_valid", 384'(out_valid8), 384'd0);
    @(posedge clk); #1; in_valid8 = 1'b0;
    check("b2b second taken", 384'(in_ready8), 384'd0);
    wait8(lat);
    check("b2b second latency", 384'(lat), 384'd10);
    check("b2b second result", 384'(result8), 384'(mont8(9, 11, 13)));
    accept8();

    // Reset in the middle of LOOP aborts with no output
    send8(5, 7, 13);
    repeat (5) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    #1;
    check("midreset in_ready", 384'(in_ready8), 384'd1);
    check("midreset out_valid", 384'(out_valid8), 384'd0);
    check("midreset result", 384'(result8), 384'd0);
    @(negedge clk); @(negedge clk); resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid8 === 1'b1) seen = 1'b1;
    end
    check("aborted no output", 384'(seen), 384'd0);
    check("aborted in_ready", 384'(in_ready8), 384'd1);
    run8("post-reset 5x7", 5, 7, 13);

    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(3, 255) | 1;
      a = $urandom_range(0, m - 1);
      b = $urandom_range(0, m - 1);
      run8("rand8", a, b, m);
    end

    // 381-bit: a = 2^381 mod m turns the product into b itself
    t1 = (768'd1 << 381) % mm;
    ra = t1[380:0];
    t2 = rand_below_m();
    rb = t2[380:0];
    run_w(ra, rb, rr, lat);
    check("w381 identity latency", 384'(lat), 384'd383);
    check("w381 identity result", 384'(rr), 384'(rb));
    check("w381 err", 384'(out_err_w), 384'd0);

    for (int i = 0; i < 24; i++) begin
      t1 = rand_below_m(); ra = t1[380:0];
      t2 = rand_below_m(); rb = t2[380:0];
      run_w(ra, rb, rr, lat);
      check("w381 latency", 384'(lat), 384'd383);
      check("w381 range", 384'({767'd0, rr}) < 384'(mm) ? 384'd1 : 384'd0, 384'd1);
      t1 = ({387'd0, rr} << 381) % mm;
      t2 = ({387'd0, ra} * {387'd0, rb}) % mm;
      check("w381 congruence", t1[383:0], t2[383:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
